// File: rtl/booth_r4_seq_mult.sv
// Iterative radix-4 Booth multiplier: one Booth digit retired per clock into a
// wide accumulator, signed/unsigned selected per operation, valid/ready on both sides.
module booth_r4_seq_mult #(
    parameter int unsigned WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               signed_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product_o,
    output logic               busy_o
);

    localparam int unsigned AW     = 2*WIDTH + 4;
    localparam int unsigned BW     = WIDTH + 3;
    localparam int unsigned ND_MAX = WIDTH/2 + 1;
    localparam int unsigned CW     = $clog2(ND_MAX + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state, state_nx;
    logic [AW-1:0] acc, acc_nx, a_sh, a_ext_c, pp;
    logic [BW-1:0] b_sh, b_ext_c;
    logic [CW-1:0] cnt, last_idx;
    logic          neg, accept, last_digit;

    // Next state, operand extension and the Booth partial product for the current digit
    always_comb begin
        state_nx   = state;
        pp         = '0;
        neg        = 1'b0;
        accept     = (state == IDLE) && in_valid && in_ready;
        last_digit = (cnt == last_idx);
        a_ext_c    = {{(AW-WIDTH){signed_i & a_i[WIDTH-1]}}, a_i};
        b_ext_c    = {{2{signed_i & b_i[WIDTH-1]}}, b_i, 1'b0};

        case (b_sh[2:0])
            3'b001, 3'b010: pp = a_sh;
            3'b011:         pp = a_sh << 1;
            3'b100: begin
                pp  = ~(a_sh << 1);
                neg = 1'b1;
            end
            3'b101, 3'b110: begin
                pp  = ~a_sh;
                neg = 1'b1;
            end
            default:        pp = '0;
        endcase

        // negation completes through the carry-in of the same add
        acc_nx = acc + pp + AW'(neg);

        case (state)
            IDLE:    if (accept)     state_nx = RUN;
            RUN:     if (last_digit) state_nx = DONE;
            DONE:    if (out_ready)  state_nx = IDLE;
            default:                 state_nx = IDLE;
        endcase
    end

    // State, datapath and registered handshake outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            a_sh      <= '0;
            b_sh      <= '0;
            cnt       <= '0;
            last_idx  <= '0;
            product_o <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b0;
            busy_o    <= 1'b0;
        end else begin
            state    <= state_nx;
            in_ready <= (state_nx == IDLE);
            busy_o   <= (state_nx != IDLE);

            case (state)
                IDLE: begin
                    if (accept) begin
                        a_sh     <= a_ext_c;
                        b_sh     <= b_ext_c;
                        acc      <= '0;
                        cnt      <= '0;
                        // unsigned needs one extra digit to absorb the multiplier MSB
                        last_idx <= signed_i ? CW'(WIDTH/2 - 1) : CW'(WIDTH/2);
                    end
                end
                RUN: begin
                    acc  <= acc_nx;
                    a_sh <= a_sh << 2;
                    b_sh <= b_sh >> 2;
                    cnt  <= cnt + CW'(1);
                    if (last_digit) begin
                        product_o <= acc_nx[2*WIDTH-1:0];
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_r4_seq_mult.sv
// Bench for booth_r4_seq_mult: directed cases on a 16-bit instance plus
// concurrent randomized regressions on 4/8/16/32-bit instances against an arithmetic model.
module tb_booth_r4_seq_mult;

    localparam int NOPS = 300;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int rnd_done = 0;

    logic        rst = 1'b1;
    logic        d_in_valid = 1'b0, d_signed = 1'b0, d_out_ready = 1'b0;
    logic [15:0] d_a = '0, d_b = '0;
    logic        d_in_ready, d_out_valid, d_busy;
    logic [31:0] d_product;

    booth_r4_seq_mult #(.WIDTH(16)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (d_in_valid),
        .in_ready  (d_in_ready),
        .signed_i  (d_signed),
        .a_i       (d_a),
        .b_i       (d_b),
        .out_valid (d_out_valid),
        .out_ready (d_out_ready),
        .product_o (d_product),
        .busy_o    (d_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Exact product of two w-bit operands, interpreted signed or unsigned
    function automatic logic [63:0] ref_prod(input int w, input bit s,
                                             input logic [63:0] a, input logic [63:0] b);
        longint sa, sb;
        sa = longint'(a);
        sb = longint'(b);
        if (s) begin
            sa = (sa <<< (64 - w)) >>> (64 - w);
            sb = (sb <<< (64 - w)) >>> (64 - w);
        end
        return 64'(sa * sb);
    endfunction

    task automatic run_op(input string tag, input bit s, input logic [15:0] a,
                          input logic [15:0] b, input logic [31:0] exp);
        int w, lat;
        d_signed = s; d_a = a; d_b = b; d_in_valid = 1'b1; w = 0;
        while (!d_in_ready && w < 50) begin tick(); w++; end
        chk({tag, "_accept"}, 64'(w < 50), 64'd1);
        tick();
        d_in_valid = 1'b0; d_a = 16'($urandom); d_b = 16'($urandom); d_signed = ~s;
        chk({tag, "_busy"}, 64'(d_busy), 64'd1);
        lat = 0;
        while (!d_out_valid && lat < 40) begin tick(); lat++; end
        chk({tag, "_latency"}, 64'(lat), s ? 64'd8 : 64'd9);
        chk({tag, "_product"}, 64'(d_product), 64'(exp));
        d_out_ready = 1'b1;
        tick();
        d_out_ready = 1'b0;
        chk({tag, "_valid_drop"}, 64'(d_out_valid), 64'd0);
        chk({tag, "_ready_back"}, 64'(d_in_ready), 64'd1);
    endtask

    // Randomized regressions, one instance per width
    for (genvar g = 0; g < 4; g++) begin : g_rnd
        localparam int unsigned W = 4 << g;
        logic           r_rst, r_iv, r_ir, r_s, r_ov, r_or, r_busy;
        logic [W-1:0]   r_a, r_b;
        logic [2*W-1:0] r_p;

        booth_r4_seq_mult #(.WIDTH(W)) u_dut (
            .clk       (clk),
            .rst       (r_rst),
            .in_valid  (r_iv),
            .in_ready  (r_ir),
            .signed_i  (r_s),
            .a_i       (r_a),
            .b_i       (r_b),
            .out_valid (r_ov),
            .out_ready (r_or),
            .product_o (r_p),
            .busy_o    (r_busy)
        );

        initial begin
            int w, lat, gap;
            bit s;
            logic [W-1:0] a, b;
            logic [63:0] e;
            logic [2*W-1:0] e_w;
            r_rst = 1'b1; r_iv = 1'b0; r_s = 1'b0; r_a = '0; r_b = '0; r_or = 1'b0;
            tick(); tick();
            r_rst = 1'b0;
            tick();
            for (int op = 0; op < NOPS; op++) begin
                s = 1'($urandom);
                a = W'($urandom);
                b = W'($urandom);
                case ($urandom_range(0, 5))
                    0: a = '1;
                    1: a = W'(1) << (W - 1);
                    2: b = W'(1) << (W - 1);
                    3: b = '1;
                    default: ;
                endcase
                e   = ref_prod(W, s, 64'(a), 64'(b));
                e_w = e[2*W-1:0];
                gap = $urandom_range(0, 3);
                repeat (gap) tick();
                r_s = s; r_a = a; r_b = b; r_iv = 1'b1; w = 0;
                while (!r_ir && w < 50) begin tick(); w++; end
                chk($sformatf("rnd%0d_accept", W), 64'(w < 50), 64'd1);
                tick();
                chk($sformatf("rnd%0d_busy", W), 64'(r_busy), 64'd1);
                lat = 0;
                while (!r_ov && lat < 60) begin
                    r_iv = 1'($urandom); r_s = 1'($urandom);
                    r_a = W'($urandom);  r_b = W'($urandom);
                    r_or = 1'($urandom);
                    tick();
                    lat++;
                end
                r_iv = 1'b0; r_or = 1'b0;
                chk($sformatf("rnd%0d_latency", W), 64'(lat), s ? 64'(W/2) : 64'(W/2 + 1));
                gap = $urandom_range(0, 3);
                repeat (gap) tick();
                chk($sformatf("rnd%0d_valid_held", W), 64'(r_ov), 64'd1);
                chk($sformatf("rnd%0d_product a=%0h b=%0h s=%0d", W, a, b, s), 64'(r_p), 64'(e_w));
                r_or = 1'b1;
                tick();
                r_or = 1'b0;
                chk($sformatf("rnd%0d_no_dup", W), 64'(r_ov), 64'd0);
                chk($sformatf("rnd%0d_ready_back", W), 64'(r_ir), 64'd1);
            end
            rnd_done++;
        end
    end

    initial begin
        int w, lat;
        logic [63:0] e64;
        logic [31:0] e1, e2;

        #12;
        chk("reset_in_ready", 64'(d_in_ready), 64'd0);
        chk("reset_out_valid", 64'(d_out_valid), 64'd0);
        chk("reset_product", 64'(d_product), 64'd0);
        chk("reset_busy", 64'(d_busy), 64'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("release_in_ready", 64'(d_in_ready), 64'd1);

        run_op("signed_min_sq", 1'b1, 16'h8000, 16'h8000, 32'h40000000);
        run_op("unsigned_max_sq", 1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001);
        run_op("signed_max_min", 1'b1, 16'h7FFF, 16'h8000, 32'hC0008000);
        run_op("signed_m1_x1", 1'b1, 16'hFFFF, 16'h0001, 32'hFFFFFFFF);
        run_op("unsigned_ffff_x1", 1'b0, 16'hFFFF, 16'h0001, 32'h0000FFFF);

        // Backpressure with in_valid held high across DONE
        e64 = ref_prod(16, 1'b0, 64'h1234, 64'h5678);
        e1  = e64[31:0];
        e64 = ref_prod(16, 1'b1, 64'h8001, 64'h7FFF);
        e2  = e64[31:0];
        d_signed = 1'b0; d_a = 16'h1234; d_b = 16'h5678; d_in_valid = 1'b1; w = 0;
        while (!d_in_ready && w < 50) begin tick(); w++; end
        tick();
        d_signed = 1'b1; d_a = 16'h8001; d_b = 16'h7FFF;
        lat = 0;
        while (!d_out_valid && lat < 40) begin tick(); lat++; end
        chk("bp_latency", 64'(lat), 64'd9);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp_valid_%0d", i), 64'(d_out_valid), 64'd1);
            chk($sformatf("bp_product_%0d", i), 64'(d_product), 64'(e1));
            chk($sformatf("bp_in_ready_%0d", i), 64'(d_in_ready), 64'd0);
            tick();
        end
        d_out_ready = 1'b1;
        tick();
        d_out_ready = 1'b0;
        chk("bp_idle_ready", 64'(d_in_ready), 64'd1);
        chk("bp_valid_drop", 64'(d_out_valid), 64'd0);
        chk("bp_product_hold", 64'(d_product), 64'(e1));
        tick();
        d_in_valid = 1'b0;
        chk("bp_next_accepted", 64'(d_busy), 64'd1);
        chk("bp_next_in_ready", 64'(d_in_ready), 64'd0);
        lat = 0;
        while (!d_out_valid && lat < 40) begin tick(); lat++; end
        chk("bp_next_latency", 64'(lat), 64'd8);
        chk("bp_next_product", 64'(d_product), 64'(e2));
        d_out_ready = 1'b1;
        tick();
        d_out_ready = 1'b0;

        // Reset three cycles into RUN
        d_signed = 1'b1; d_a = 16'h1111; d_b = 16'h2222; d_in_valid = 1'b1; w = 0;
        while (!d_in_ready && w < 50) begin tick(); w++; end
        tick();
        d_in_valid = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        #1;
        chk("abort_out_valid", 64'(d_out_valid), 64'd0);
        chk("abort_product", 64'(d_product), 64'd0);
        chk("abort_in_ready", 64'(d_in_ready), 64'd0);
        chk("abort_busy", 64'(d_busy), 64'd0);
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("abort_release_ready", 64'(d_in_ready), 64'd1);
        run_op("after_abort", 1'b1, 16'd3, 16'hFFFB, 32'hFFFFFFF1);

        w = 0;
        while (rnd_done < 4 && w < 60000) begin tick(); w++; end
        chk("random_regressions_done", 64'(rnd_done), 64'd4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
